// File: rtl/ex_mem_register_pkg.sv
// Purpose: shared constants for the EX->MEM boundary (flag bit positions, zero register, widths).
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ex_mem_register_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int FLAG_W     = 3;

  // Bit positions inside the alu flag vector.
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_NEG  = 2;

  // Architectural zero register: reads as 0, so it is never a forwarding source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when the ALU reported signed overflow for this result.
  function automatic logic is_overflow(input logic [FLAG_W-1:0] flag);
    return flag[FLAG_OVF];
  endfunction

endpackage

// File: rtl/ex_mem_register_fwd_compare.sv
// Purpose: decides whether a live MEM-stage writer supplies one EX source operand.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from registered MEM state.
module ex_mem_register_fwd_compare
  import ex_mem_register_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              valid,
  input  logic              we,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  output logic              match
);

  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign match = valid & we & (rd != REG_AW'(REG_ZERO)) & (rd == rs);

endmodule

// File: rtl/ex_mem_register.sv
// Purpose: EX->MEM pipeline register with flush, overflow trap, branch redirect and operand forwarding.
// Latency: 1 cycle from EX inputs to mem_* outputs; forwarding is combinational from the MEM registers.
// Backpressure: stall holds every MEM register and suppresses redirect; stall outranks flush, reset outranks both.
module ex_mem_register
  import ex_mem_register_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [FLAG_W-1:0] ex_flag,
  input  logic              ex_branch,
  input  logic              ex_is_branch,
  input  logic [DATA_W-1:0] ex_target,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              exc_ack,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_result,
  output logic [FLAG_W-1:0] mem_flag,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [DATA_W-1:0] fwd_data,
  output logic              exc
);

  logic capture_ok;
  logic ovf_kill;
  logic take_branch;

  // A flushed or empty EX slot becomes a bubble in MEM.
  assign capture_ok  = ex_valid & ~flush;
  // Overflow keeps the instruction live (so the trap has an owner) but blocks its architectural writes.
  assign ovf_kill    = OVF_TRAP & capture_ok & is_overflow(ex_flag);
  assign take_branch = capture_ok & ex_is_branch & ex_branch;

  // Pipeline register: capture on every unstalled edge; redirect is a single pulse per captured branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_flag       <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      redirect       <= 1'b0;
      redirect_pc    <= '0;
    end else if (stall) begin
      // Hold everything; a held branch must not re-pulse redirect.
      redirect <= 1'b0;
    end else begin
      mem_valid      <= capture_ok;
      // Data fields load unconditionally; they are meaningless while mem_valid is low.
      mem_result     <= ex_result;
      mem_flag       <= {ex_flag[FLAG_NEG], ex_flag[FLAG_OVF], ex_flag[FLAG_ZERO]};
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      mem_reg_write  <= capture_ok & ex_reg_write & ~ovf_kill;
      mem_mem_read   <= capture_ok & ex_mem_read;
      mem_mem_write  <= capture_ok & ex_mem_write & ~ovf_kill;
      redirect       <= take_branch;
      if (take_branch) begin
        redirect_pc <= ex_target;
      end
    end
  end

  // Sticky trap flag: a new overflow in the same cycle as an ack keeps it set.
  always_ff @(posedge clock) begin
    if (reset) begin
      exc <= 1'b0;
    end else if (!stall && ovf_kill) begin
      exc <= 1'b1;
    end else if (exc_ack) begin
      exc <= 1'b0;
    end
  end

  assign fwd_data = mem_result;

  ex_mem_register_fwd_compare #(.REG_AW(REG_AW)) u_fwd_a (
    .valid (mem_valid),
    .we    (mem_reg_write),
    .rd    (mem_rd),
    .rs    (id_rs),
    .match (fwd_a)
  );

  ex_mem_register_fwd_compare #(.REG_AW(REG_AW)) u_fwd_b (
    .valid (mem_valid),
    .we    (mem_reg_write),
    .rd    (mem_rd),
    .rs    (id_rt),
    .match (fwd_b)
  );

endmodule
